turn_lever_conditioner: RTL

Input conditioning stage that sits directly upstream of the Thunderbird turn-signal FSM. It takes the raw, asynchronous, bouncy left/right lever contacts and synchronizes and debounces them. It then presents clean left/right levels to the FSM, changing only on a periodic step strobe. It also generates that step strobe (tick), which slows the FSM's lamp sequencing to a visible rate.

---
 rtl/turn_lever_conditioner_pkg.sv | 15 +
 rtl/turn_lever_conditioner_if.sv | 29 ++
 rtl/turn_lever_conditioner_debounce.sv | 55 +++++
 rtl/turn_lever_conditioner.sv | 74 +++++++
 4 files changed

// File: rtl/turn_lever_conditioner_pkg.sv
// Shared defaults and width helpers for the turn-lever input conditioner.
package turn_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int TICK_DIV_DEF        = 8;

   // Counter widths never drop below one bit so degenerate sizes still elaborate.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEBOUNCE_CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);
   localparam int TICK_CNT_W_DEF     = cnt_width(TICK_DIV_DEF);

endpackage

// File: rtl/turn_lever_conditioner_if.sv
// Lever-side signals between the raw contacts, the conditioner and the turn-signal FSM.
interface turn_lever_conditioner_if;

   logic raw_left;
   logic raw_right;
   logic left;
   logic right;
   logic tick;
   logic busy;

   modport master (
      output raw_left,
      output raw_right,
      input  left,
      input  right,
      input  tick,
      input  busy
   );

   modport slave (
      input  raw_left,
      input  raw_right,
      output left,
      output right,
      output tick,
      output busy
   );

endinterface

// File: rtl/turn_lever_conditioner_debounce.sv
// One lever channel: two-flop synchronizer followed by a saturating debounce counter.
module lever_debounce
   import turn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic db,
   output logic busy
);

   localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             db_q, db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any sample agreeing with the debounced level restarts the count.
   always_comb begin
      s1_d  = raw;
      s2_d  = s1_q;
      db_d  = db_q;
      cnt_d = '0;
      if (s2_q != db_q) begin
         if (cnt_q == CNT_MAX) begin
            db_d  = s2_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign db   = db_q;
   assign busy = |cnt_q;

endmodule

// File: rtl/turn_lever_conditioner.sv
// Conditions raw turn-lever contacts into clean left/right requests and a step tick
// for the Thunderbird turn-signal FSM.
module turn_lever_conditioner
   import turn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int TICK_DIV        = TICK_DIV_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   turn_lever_conditioner_if.slave   lever
);

   localparam int                TICK_W   = cnt_width(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

   logic              db_left, db_right;
   logic              busy_left, busy_right;
   logic              tick;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              left_q, left_d;
   logic              right_q, right_d;

   lever_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_left_db (
      .clk   (clk),
      .reset (reset),
      .raw   (lever.raw_left),
      .db    (db_left),
      .busy  (busy_left)
   );

   lever_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_right_db (
      .clk   (clk),
      .reset (reset),
      .raw   (lever.raw_right),
      .db    (db_right),
      .busy  (busy_right)
   );

   assign tick = (tick_cnt_q == TICK_MAX);

   // Requests only move on tick edges; both sides pass together as a hazard request.
   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
      left_d     = left_q;
      right_d    = right_q;
      if (tick) begin
         left_d  = db_left;
         right_d = db_right;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_cnt_q <= '0;
         left_q     <= 1'b0;
         right_q    <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         left_q     <= left_d;
         right_q    <= right_d;
      end
   end

   assign lever.left  = left_q;
   assign lever.right = right_q;
   assign lever.tick  = tick;
   assign lever.busy  = busy_left | busy_right;

endmodule
